spi_mem_model: RTL and testbench
================================

SPI_MEM_MODEL -- requirements
Module: spi_mem_model

Interface
REQ-001 Parameter ADDR_W, default 24: address bits received after the command byte; legal values are 16 or 24.
REQ-002 Parameter DEPTH_LOG2, default 12: the array holds 2**DEPTH_LOG2 bytes; DEPTH_LOG2 SHALL be ≤ ADDR_W.
REQ-003 Parameter WRITABLE, default 1: 1 gives PSRAM behaviour (0x02 write accepted), 0 gives flash behaviour (read-only).
REQ-004 clk  in  1  system clock; SHALL run at ≥ 8x SCLK frequency.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 sclk_in  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 cs_in  in  1  chip select, active-low.
REQ-008 mosi_in  in  1  serial data in, MSB first.
REQ-009 miso_out  out  1  serial data out, MSB first.
REQ-010 miso_oe  out  1  high while the block drives miso_out; when low, the bench tri-states the line.
REQ-011 bd_we, bd_addr[DEPTH_LOG2-1:0], bd_wdata[7:0]  in  backdoor preload port; writes 1 byte per clk while bd_we=1.

Function
REQ-012 sclk_in, cs_in and mosi_in SHALL each pass through 2 flops; edges are detected from the 2nd flop against a 3rd, delayed copy.
REQ-013 Sample mosi on each detected SCLK rise; update miso_out on each detected SCLK fall; an updated bit appears on miso_out 1 clk after fall detection.
REQ-014 States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
REQ-015 A synchronised cs falling edge moves IDLE→CMD and clears the bit counter.
REQ-016 CMD leaves after 8 rises. 0x03→ADDR (read); 0x02 with WRITABLE=1→ADDR (write); 0x0B→ADDR (fast read, see REQ-027); any other value→IGNORE.
REQ-017 ADDR leaves after ADDR_W rises: reads go to READ, writes go to WRITE, fast read goes to DUMMY. Only the low DEPTH_LOG2 address bits are used.
REQ-018 READ fetches mem[addr] into the shift register. Its MSB is driven on the first SCLK fall after the last address or dummy bit. Each 8 bits, addr increments and the next byte loads.
REQ-019 WRITE assembles 8 rises into a byte, commits it to mem[addr] 1 clk after the 8th rise, then increments addr.
REQ-020 Address increment wraps from 2**DEPTH_LOG2-1 to 0 in both READ and WRITE.
REQ-021 IGNORE discards all traffic until cs deasserts.
REQ-022 miso_oe=1 only in READ with cs low; otherwise miso_oe=0 and miso_out=0.
REQ-023 A synchronised cs rise in any state SHALL return to IDLE within 1 clk. A partially received write byte SHALL be discarded; any read or write in progress is aborted.
REQ-024 If bd_we and a SPI write commit hit the same clk, the backdoor write SHALL win and the SPI byte SHALL be dropped. The address still increments.
REQ-025 A backdoor write to the byte currently held in the READ shift register SHALL NOT alter that register; it affects the next fetch only.

Reset
REQ-026 While rst_n=0 at a clk rise: state→IDLE, counters→0, shift registers→0, synchroniser flops→cs=1, sclk=0, mosi=0, miso_out=0, miso_oe=0. Memory contents are NOT reset. Reset mid-transaction aborts it, and the block ignores the bus until the next cs fall.

Configuration
REQ-027 Macro SPI_MEM_FASTREAD_EN. Defined: 0x0B is accepted and ADDR→DUMMY, which consumes 8 rises with miso_oe=0 before READ. Undefined: 0x0B→IGNORE and the DUMMY state is not built.

Verification
REQ-028 Preload mem[0x010..0x013]=A5,3C,00,FF by backdoor; issue 0x03 at addr 0x000010 and clock 32 bits → miso returns A5 3C 00 FF; miso_oe=1 only during data bits.
REQ-029 WRITABLE=1: 0x02 at addr 0x000FFF with data 11,22 → mem[0xFFF]=11, mem[0x000]=22 (wrap); read back both via 0x03.
REQ-030 WRITABLE=0: 0x02 then read → memory unchanged, miso_oe stays 0 during the write attempt; unknown command 0x9F → miso_oe=0 for the whole transaction.
REQ-031 SPI_MEM_FASTREAD_EN defined: 0x0B at addr 0x000010 plus 8 dummy bits → A5 returned. Undefined: same sequence → miso_oe=0 throughout.
REQ-032 Raise cs after 5 data bits of a 0x02 write → target byte unchanged; the next cs fall starts a clean CMD state. Assert rst_n=0 mid-READ → miso_oe=0 one clk later.

Source files
------------

// File: rtl/spi_mem_model.sv
// spi_mem_model
//   Behavioural-but-synthesizable SPI memory device (PSRAM or serial flash),
//   SPI mode 0, MSB first. The SPI pins are oversampled by the system clock.
//   Commands: 0x03 read, 0x02 write (only when WRITABLE=1) and, when
//   SPI_MEM_FASTREAD_EN is defined, 0x0B fast read with 8 dummy bits.
//   Any other command is ignored until chip select is released.
//
// Build option:
//   SPI_MEM_FASTREAD_EN  - when defined, 0x0B is accepted and the DUMMY state
//                          is built; when undefined, 0x0B is ignored.
//
// Parameters:
//   ADDR_W      address bits after the command byte (16 or 24)
//   DEPTH_LOG2  log2 of the array size in bytes (<= ADDR_W)
//   WRITABLE    1 = PSRAM (writes accepted), 0 = flash (read-only)
//
// Ports:
//   clk       system clock, at least 8x the SCLK frequency
//   rst_n     synchronous active-low reset
//   sclk_in   SPI clock
//   cs_in     chip select, active-low
//   mosi_in   serial data in
//   miso_out  serial data out (0 whenever miso_oe is low)
//   miso_oe   high while the device drives miso_out
//   bd_we     backdoor write strobe, one byte per clk
//   bd_addr   backdoor byte address
//   bd_wdata  backdoor byte data
module spi_mem_model #(
  parameter int ADDR_W     = 24,
  parameter int DEPTH_LOG2 = 12,
  parameter int WRITABLE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_in,
  input  logic                  cs_in,
  input  logic                  mosi_in,
  output logic                  miso_out,
  output logic                  miso_oe,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [7:0]            bd_wdata
);

  localparam int              CNT_W     = 5;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

`ifdef SPI_MEM_FASTREAD_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
`endif

  state_t state, state_nxt;

  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  logic [CNT_W-1:0]      bit_cnt;
  logic [2:0]            rd_cnt;
  logic [6:0]            sh_in;
  logic [DEPTH_LOG2-2:0] addr_sh;
  logic [DEPTH_LOG2-1:0] addr;
  logic [DEPTH_LOG2-1:0] addr_inc;
  logic [DEPTH_LOG2-1:0] addr_full;
  logic [7:0]            shift_byte;
  logic [7:0]            tx_sh;
  logic [7:0]            wr_byte;
  logic                  miso_q;
  logic                  commit;
  logic                  op_wr;
`ifdef SPI_MEM_FASTREAD_EN
  logic                  op_fast;
`endif

  logic sclk_rise, sclk_fall, cs_fall;

  // Stage p0/p1: two-flop synchronisers; stage p2: delayed copy for edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk_in;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= cs_in;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= mosi_in;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise  = sclk_p1 & ~sclk_p2;
  assign sclk_fall  = ~sclk_p1 & sclk_p2;
  assign cs_fall    = ~cs_p1 & cs_p2;
  assign shift_byte = {sh_in, mosi_p1};
  // Only the low DEPTH_LOG2 address bits are kept; upper bits shift out.
  assign addr_full  = {addr_sh, mosi_p1};
  assign addr_inc   = addr + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cs_fall) state_nxt = CMD;
      CMD: begin
        if (sclk_rise && bit_cnt == BYTE_LAST) begin
          case (shift_byte)
            8'h03:   state_nxt = ADDR;
            8'h02:   state_nxt = (WRITABLE != 0) ? ADDR : IGNORE;
`ifdef SPI_MEM_FASTREAD_EN
            8'h0B:   state_nxt = ADDR;
`endif
            default: state_nxt = IGNORE;
          endcase
        end
      end
      ADDR: begin
        if (sclk_rise && bit_cnt == ADDR_LAST) begin
          if (op_wr)        state_nxt = WRITE;
`ifdef SPI_MEM_FASTREAD_EN
          else if (op_fast) state_nxt = DUMMY;
`endif
          else              state_nxt = READ;
        end
      end
`ifdef SPI_MEM_FASTREAD_EN
      DUMMY: if (sclk_rise && bit_cnt == BYTE_LAST) state_nxt = READ;
`endif
      default: state_nxt = state;
    endcase
    // Chip select released: abort whatever is in progress.
    if (state != IDLE && cs_p1) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rd_cnt  <= '0;
      sh_in   <= '0;
      addr_sh <= '0;
      addr    <= '0;
      tx_sh   <= '0;
      wr_byte <= '0;
      miso_q  <= 1'b0;
      commit  <= 1'b0;
      op_wr   <= 1'b0;
`ifdef SPI_MEM_FASTREAD_EN
      op_fast <= 1'b0;
`endif
    end else begin
      commit <= 1'b0;
      // The address advances after a commit even if the backdoor won the port.
      if (commit) addr <= addr_inc;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt <= '0;
            sh_in   <= '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            sh_in <= shift_byte[6:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              op_wr   <= (shift_byte == 8'h02);
`ifdef SPI_MEM_FASTREAD_EN
              op_fast <= (shift_byte == 8'h0B);
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            addr_sh <= addr_full[DEPTH_LOG2-2:0];
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              rd_cnt  <= '0;
              addr    <= addr_full;
              tx_sh   <= mem[addr_full];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef SPI_MEM_FASTREAD_EN
        DUMMY: begin
          if (sclk_rise) begin
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              rd_cnt  <= '0;
              tx_sh   <= mem[addr];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`endif
        READ: begin
          if (sclk_fall) begin
            miso_q <= tx_sh[7];
            rd_cnt <= rd_cnt + 1'b1;
            // Last bit of the byte is going out: prefetch the next byte now so
            // its MSB is ready for the following fall.
            if (rd_cnt == 3'd7) begin
              addr  <= addr_inc;
              tx_sh <= mem[addr_inc];
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            sh_in <= shift_byte[6:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              wr_byte <= shift_byte;
              commit  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (state != READ) miso_q <= 1'b0;
    end
  end

  // Memory array is not reset; the backdoor has priority over an SPI commit.
  always_ff @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_wdata;
    else if (commit) mem[addr]    <= wr_byte;
  end

  assign miso_oe  = (state == READ) && !cs_p1;
  assign miso_out = miso_oe & miso_q;

endmodule

// File: tb/tb_spi_mem_model.sv
module tb_spi_mem_model;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk_in, mosi_in;
  logic        cs_a, cs_b;
  logic        miso_a, oe_a, miso_b, oe_b;
  logic        bd_we_a, bd_we_b;
  logic [11:0] bd_addr;
  logic [7:0]  bd_wdata;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_mem_model u_a (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .cs_in(cs_a), .mosi_in(mosi_in),
    .miso_out(miso_a), .miso_oe(oe_a),
    .bd_we(bd_we_a), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  spi_mem_model #(.WRITABLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .cs_in(cs_b), .mosi_in(mosi_in),
    .miso_out(miso_b), .miso_oe(oe_b),
    .bd_we(bd_we_b), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input bit sel, input logic [11:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    if (sel) bd_we_b = 1'b1;
    else     bd_we_a = 1'b1;
    @(negedge clk);
    bd_we_a = 1'b0;
    bd_we_b = 1'b0;
  endtask

  task automatic sclk_bit(input bit sel, input logic b, output logic r, output logic o);
    mosi_in = b;
    repeat (HALF) @(negedge clk);
    r = sel ? miso_b : miso_a;
    o = sel ? oe_b : oe_a;
    sclk_in = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk_in = 1'b0;
  endtask

  task automatic xfer_bits(input bit sel, input int n, input logic [7:0] tx,
                           output logic [7:0] rx, output logic oe_any, output logic oe_all);
    logic r, o;
    rx = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      sclk_bit(sel, tx[7-i], r, o);
      rx     = {rx[6:0], r};
      oe_any = oe_any | o;
      oe_all = oe_all & o;
    end
  endtask

  task automatic cs_start(input bit sel);
    if (sel) cs_b = 1'b0;
    else     cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_stop();
    repeat (HALF) @(negedge clk);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (3*HALF) @(negedge clk);
  endtask

  // Command plus three address bytes; the device must never drive during them.
  task automatic send_hdr(input bit sel, input logic [7:0] cmd, input logic [23:0] a,
                          input string tag);
    logic [7:0] rx, hb[4];
    logic oe_any_v, oe_all_v;
    hb[0] = cmd; hb[1] = a[23:16]; hb[2] = a[15:8]; hb[3] = a[7:0];
    for (int k = 0; k < 4; k++) begin
      xfer_bits(sel, 8, hb[k], rx, oe_any_v, oe_all_v);
      check($sformatf("%s_hdr%0d_oe", tag, k), {31'b0, oe_any_v}, 32'd0);
    end
  endtask

  task automatic read_expect(input bit sel, input string tag);
    logic [7:0] rx, exp;
    logic oe_any_v, oe_all_v;
    xfer_bits(sel, 8, 8'h00, rx, oe_any_v, oe_all_v);
    exp = exp_q.pop_front();
    check({tag, "_data"}, {24'b0, rx}, {24'b0, exp});
    check({tag, "_oe"}, {31'b0, oe_all_v}, 32'd1);
  endtask

  task automatic write_byte(input bit sel, input logic [7:0] d, input string tag);
    logic [7:0] rx;
    logic oe_any_v, oe_all_v;
    xfer_bits(sel, 8, d, rx, oe_any_v, oe_all_v);
    check({tag, "_oe"}, {31'b0, oe_any_v}, 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx1, rx2;
    logic oe_any_v, oe_all_v;

    rst_n = 1'b0; sclk_in = 1'b0; mosi_in = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
    bd_we_a = 1'b0; bd_we_b = 1'b0; bd_addr = '0; bd_wdata = '0;
    repeat (4) @(negedge clk);
    check("rst_oe_a", {31'b0, oe_a}, 32'd0);
    check("rst_miso_a", {31'b0, miso_a}, 32'd0);
    check("rst_oe_b", {31'b0, oe_b}, 32'd0);
    check("rst_miso_b", {31'b0, miso_b}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    bd_write(0, 12'h010, 8'hA5); bd_write(0, 12'h011, 8'h3C);
    bd_write(0, 12'h012, 8'h00); bd_write(0, 12'h013, 8'hFF);
    bd_write(0, 12'h030, 8'h77);
    bd_write(1, 12'h020, 8'h5A);

    // Basic read of four preloaded bytes
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000010, "rd");
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    repeat (4) read_expect(0, "rd");
    cs_stop();
    check("rd_idle_oe", {31'b0, oe_a}, 32'd0);

    // Write across the top of the array, then read back across the wrap
    cs_start(0);
    send_hdr(0, 8'h02, 24'h000FFF, "wr");
    write_byte(0, 8'h11, "wr_d0");
    write_byte(0, 8'h22, "wr_d1");
    cs_stop();
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000FFF, "wrap");
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    repeat (2) read_expect(0, "wrap");
    cs_stop();

    // Read-only device: write is ignored
    cs_start(1);
    send_hdr(1, 8'h02, 24'h000020, "ro_wr");
    write_byte(1, 8'h00, "ro_wr_d");
    cs_stop();
    cs_start(1);
    send_hdr(1, 8'h03, 24'h000020, "ro_rd");
    exp_q.push_back(8'h5A);
    read_expect(1, "ro_rd");
    cs_stop();

    // Unknown command
    cs_start(0);
    send_hdr(0, 8'h9F, 24'h000010, "unk");
    write_byte(0, 8'h00, "unk_d");
    cs_stop();

    // Fast read with 8 dummy bits
    cs_start(0);
    send_hdr(0, 8'h0B, 24'h000010, "fast");
    write_byte(0, 8'h00, "fast_dummy");
`ifdef SPI_MEM_FASTREAD_EN
    exp_q.push_back(8'hA5);
    read_expect(0, "fast");
`else
    write_byte(0, 8'h00, "fast_off");
`endif
    cs_stop();

    // Partial write aborted by cs release; next transaction starts clean
    cs_start(0);
    send_hdr(0, 8'h02, 24'h000030, "part");
    xfer_bits(0, 5, 8'h00, rx1, oe_any_v, oe_all_v);
    cs_stop();
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000030, "part_rd");
    exp_q.push_back(8'h77);
    read_expect(0, "part_rd");
    cs_stop();

    // Reset in the middle of a read
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000010, "rstrd");
    xfer_bits(0, 3, 8'h00, rx1, oe_any_v, oe_all_v);
    check("rstrd_pre_oe", {31'b0, oe_a}, 32'd1);
    check("rstrd_pre_miso", {31'b0, miso_a}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrd_oe", {31'b0, oe_a}, 32'd0);
    check("rstrd_miso", {31'b0, miso_a}, 32'd0);
    cs_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000011, "post_rst");
    exp_q.push_back(8'h3C);
    read_expect(0, "post_rst");
    cs_stop();

    // Backdoor write during a read: held byte unaffected, next fetch sees it
    cs_start(0);
    send_hdr(0, 8'h03, 24'h000010, "bdrd");
    exp_q.push_back(8'hA5);
    xfer_bits(0, 4, 8'h00, rx1, oe_any_v, oe_all_v);
    bd_write(0, 12'h010, 8'hEE);
    bd_write(0, 12'h011, 8'h99);
    xfer_bits(0, 4, 8'h00, rx2, oe_any_v, oe_all_v);
    check("bdrd_held", {24'b0, rx1[3:0], rx2[3:0]}, {24'b0, exp_q.pop_front()});
    exp_q.push_back(8'h99);
    read_expect(0, "bdrd_next");
    cs_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
